// File: rtl/eq_out_stage.sv
// Equaliser output stage: gain, soft-mute ramp and 24-bit saturation in a
// 3-stage pipeline, with sticky clip statistics.
module eq_out_stage #(
  parameter int RAMP_STEP = 4,
  parameter int GAIN_FRAC = 14
) (
  input  logic               clk_40k,
  input  logic               rst,
  input  logic signed [28:0] din,
  input  logic               din_valid,
  input  logic        [15:0] gain,
  input  logic               mute,
  input  logic               clip_clr,
  output logic signed [23:0] dout,
  output logic               dout_valid,
  output logic               muted,
  output logic               clip_flag,
  output logic        [15:0] clip_cnt
);

  typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

  localparam logic [8:0]         RAMP_FULL = 9'd256;
  localparam logic [9:0]         STEP      = 10'(RAMP_STEP);
  localparam logic signed [30:0] SAT_MAX   = 31'sd8388607;
  localparam logic signed [30:0] SAT_MIN   = -31'sd8388608;

  state_t            state;
  logic [8:0]        ramp;
  logic [9:0]        ramp_sum;
  logic [8:0]        ramp_inc;
  logic [8:0]        ramp_dec;

  logic              v1, v2;
  logic signed [30:0] p1, p2;
  logic [8:0]        r1;

  logic signed [45:0] prod1;
  logic signed [40:0] prod2;
  logic signed [30:0] p1_d, p2_d;
  logic              sat_hi, sat_lo, clip_ev;
  logic signed [23:0] sat_val;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    ramp_sum = {1'b0, ramp} + STEP;
    ramp_inc = (ramp_sum >= 10'd256) ? RAMP_FULL : ramp_sum[8:0];
    ramp_dec = ({1'b0, ramp} > STEP) ? (ramp - STEP[8:0]) : 9'd0;

    prod1 = 46'(din) * 46'($signed({1'b0, gain}));
    p1_d  = 31'(prod1 >>> GAIN_FRAC);
    prod2 = 41'(p1) * 41'($signed({1'b0, r1}));
    p2_d  = 31'(prod2 >>> 8);

    sat_hi  = (p2 > SAT_MAX);
    sat_lo  = (p2 < SAT_MIN);
    sat_val = sat_hi ? 24'sh7fffff : (sat_lo ? 24'sh800000 : p2[23:0]);
    clip_ev = v2 && (sat_hi || sat_lo);
  end

  // Leaving an end point (MUTED/ACTIVE) steps the ramp at once; reversing
  // mid-ramp only changes direction and holds the ramp for that sample.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_40k or negedge rst) begin
    if (!rst) begin
      state <= MUTED;
      ramp  <= 9'd0;
      muted <= 1'b1;
    end else if (din_valid) begin
      case (state)
        MUTED: if (!mute) begin
          ramp  <= ramp_inc;
          state <= (ramp_inc == RAMP_FULL) ? ACTIVE : RAMP_UP;
          muted <= 1'b0;
        end
        RAMP_UP: begin
          if (mute) begin
            state <= RAMP_DOWN;
          end else begin
            ramp <= ramp_inc;
            if (ramp_inc == RAMP_FULL) state <= ACTIVE;
          end
        end
        ACTIVE: if (mute) begin
          ramp <= ramp_dec;
          if (ramp_dec == 9'd0) begin
            state <= MUTED;
            muted <= 1'b1;
          end else begin
            state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (!mute) begin
            state <= RAMP_UP;
          end else begin
            ramp <= ramp_dec;
            if (ramp_dec == 9'd0) begin
              state <= MUTED;
              muted <= 1'b1;
            end
          end
        end
        default: begin
          state <= MUTED;
          ramp  <= 9'd0;
          muted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_40k or negedge rst) begin
    if (!rst) begin
      v1         <= 1'b0;
      p1         <= '0;
      r1         <= '0;
      v2         <= 1'b0;
      p2         <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      v1         <= din_valid;
      p1         <= p1_d;
      r1         <= ramp;
      v2         <= v1;
      p2         <= p2_d;
      dout_valid <= v2;
      if (v2) dout <= sat_val;
    end
  end

  // A clear coincident with a clip leaves exactly that one event counted.
  always_ff @(posedge clk_40k or negedge rst) begin
    if (!rst) begin
      clip_flag <= 1'b0;
      clip_cnt  <= '0;
    end else if (clip_clr) begin
      clip_flag <= clip_ev;
      clip_cnt  <= {15'd0, clip_ev};
    end else if (clip_ev) begin
      clip_flag <= 1'b1;
      if (clip_cnt != 16'hffff) clip_cnt <= clip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eq_out_stage.sv
// Bench for eq_out_stage: directed scenarios plus random traffic, all checked
// against an arithmetic model of gain, ramp level, saturation and clip counts.
module tb_eq_out_stage;

  localparam int GAIN_FRAC = 14;
  localparam int RAMP_STEP = 4;

  logic               clk_40k = 1'b0;
  logic               rst;
  logic signed [28:0] din;
  logic               din_valid;
  logic        [15:0] gain;
  logic               mute;
  logic               clip_clr;
  logic signed [23:0] dout;
  logic               dout_valid;
  logic               muted;
  logic               clip_flag;
  logic        [15:0] clip_cnt;

  eq_out_stage #(.RAMP_STEP(RAMP_STEP), .GAIN_FRAC(GAIN_FRAC)) dut (
    .clk_40k   (clk_40k),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .gain      (gain),
    .mute      (mute),
    .clip_clr  (clip_clr),
    .dout      (dout),
    .dout_valid(dout_valid),
    .muted     (muted),
    .clip_flag (clip_flag),
    .clip_cnt  (clip_cnt)
  );

  always #5 clk_40k = ~clk_40k;

  typedef struct {
    bit     v;
    longint d;
    bit     clip;
  } ent_t;

  // Model: the ramp is a level 0..256 plus a direction flag; muted <=> level 0.
  ent_t   pipe[3];
  int     m_ramp;
  bit     m_rising;
  longint m_dout;
  bit     m_flag;
  int     m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 0, 1'b0};
    m_ramp   = 0;
    m_rising = 0;
    m_dout   = 0;
    m_flag   = 0;
    m_cnt    = 0;
  endtask

  task automatic model_step();
    ent_t   e;
    longint p1, p2;
    bit     ev;
    e = '{1'b0, 0, 1'b0};
    if (din_valid) begin
      p1 = (longint'(din) * longint'(gain)) >>> GAIN_FRAC;
      p2 = (p1 * longint'(m_ramp)) >>> 8;
      e.v    = 1'b1;
      e.clip = (p2 > 8388607) || (p2 < -8388608);
      e.d    = (p2 > 8388607) ? 8388607 : ((p2 < -8388608) ? -8388608 : p2);
      if (!mute && m_ramp < 256) begin
        if (!m_rising && m_ramp > 0) m_rising = 1;
        else begin
          m_ramp   = (m_ramp + RAMP_STEP > 256) ? 256 : m_ramp + RAMP_STEP;
          m_rising = 1;
        end
      end else if (mute && m_ramp > 0) begin
        if (m_rising && m_ramp < 256) m_rising = 0;
        else begin
          m_ramp   = (m_ramp - RAMP_STEP < 0) ? 0 : m_ramp - RAMP_STEP;
          m_rising = 0;
        end
      end
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (pipe[2].v) m_dout = pipe[2].d;
    ev = pipe[2].v && pipe[2].clip;
    if (clip_clr) begin
      m_flag = ev;
      m_cnt  = ev ? 1 : 0;
    end else if (ev) begin
      m_flag = 1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic cycle();
    @(posedge clk_40k);
    model_step();
    #1;
    check("dout_valid", dout_valid, pipe[2].v);
    check("dout", dout, m_dout);
    check("muted", muted, (m_ramp == 0));
    check("clip_flag", clip_flag, m_flag);
    check("clip_cnt", clip_cnt, m_cnt);
  endtask

  task automatic step(input bit v, input logic signed [28:0] d, input bit clr);
    @(negedge clk_40k);
    din_valid = v;
    din       = d;
    clip_clr  = clr;
    cycle();
  endtask

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; gain = 16'd16384; mute = 1'b0; clip_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_40k);
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_muted", muted, 1);
    check("rst_clip_flag", clip_flag, 0);
    check("rst_clip_cnt", clip_cnt, 0);
    @(negedge clk_40k);
    rst = 1'b1;

    // Ramp up from reset: 64 valid samples bring the gain to unity.
    for (int j = 0; j < 64; j++) begin
      step(1'b1, 29'sd25600, 1'b0);
      if (j == 0) check("r30_muted_fall", muted, 0);
    end

    // Unity gain pass-through with 3-cycle latency, then hold.
    step(1'b1, 29'sd1000, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    check("r31_dout", dout, 1000);
    check("r31_valid", dout_valid, 1);
    check("r31_clip_cnt", clip_cnt, 0);
    step(1'b0, 29'sd0, 1'b0);
    check("r31_hold", dout, 1000);

    // Positive and negative saturation, then clear coincident with a clip.
    step(1'b1, 29'sd268435455, 1'b0);
    step(1'b1, -29'sd268435456, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    check("r32_sat_hi", dout, 8388607);
    step(1'b0, 29'sd0, 1'b0);
    check("r32_sat_lo", dout, -8388608);
    check("r32_flag", clip_flag, 1);
    check("r32_cnt", clip_cnt, 2);
    step(1'b1, 29'sd268435455, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    step(1'b0, 29'sd0, 1'b1);
    check("r32_clr_clip_cnt", clip_cnt, 1);
    check("r32_clr_clip_flag", clip_flag, 1);
    step(1'b0, 29'sd0, 1'b1);
    check("clr_only_cnt", clip_cnt, 0);
    check("clr_only_flag", clip_flag, 0);

    // Half gain rounds toward minus infinity.
    gain = 16'd8192;
    step(1'b1, -29'sd3, 1'b0);
    step(1'b1, 29'sd3, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    check("r33_floor_neg", dout, -2);
    step(1'b0, 29'sd0, 1'b0);
    check("r33_floor_pos", dout, 1);
    gain = 16'd16384;

    // Partial mute then release: down 10 steps, hold one sample, climb back.
    for (int j = 0; j < 90; j++) begin
      mute = (j < 10);
      step(1'b1, 29'sd25600, 1'b0);
      if (j == 11) check("r34_last_down", dout, 22000);
      if (j == 12) check("r34_reverse", dout, 21600);
      if (j == 13) check("r34_reverse_hold", dout, 21600);
      if (j == 14) check("r34_climb", dout, 22000);
    end
    mute = 1'b0;

    // Random traffic.
    for (int j = 0; j < 3000; j++) begin
      logic signed [28:0] d;
      if ($urandom_range(0, 23) == 0) mute = ~mute;
      if ($urandom_range(0, 39) == 0) gain = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d = 29'($urandom);
      else d = 29'($signed(21'($urandom)));
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 49) == 0));
    end

    // Reset during RAMP_UP with two samples in flight.
    gain = 16'd16384;
    mute = 1'b1;
    for (int j = 0; j < 80; j++) step(1'b1, 29'sd25600, 1'b0);
    mute = 1'b0;
    for (int j = 0; j < 5; j++) step(1'b1, 29'sd25600, 1'b0);
    step(1'b1, 29'sd12345, 1'b0);
    step(1'b1, 29'sd23456, 1'b0);
    rst = 1'b0;
    din_valid = 1'b0;
    model_reset();
    #1;
    check("r35_valid", dout_valid, 0);
    check("r35_dout", dout, 0);
    check("r35_muted", muted, 1);
    @(negedge clk_40k);
    @(negedge clk_40k);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) step(1'b0, 29'sd0, 1'b0);
    step(1'b1, 29'sd25600, 1'b0);
    step(1'b1, 29'sd25600, 1'b0);
    step(1'b0, 29'sd0, 1'b0);
    check("r35_first_ramp0", dout, 0);
    check("r35_first_valid", dout_valid, 1);
    step(1'b0, 29'sd0, 1'b0);
    check("r35_second_ramp4", dout, 400);
    for (int j = 0; j < 4; j++) step(1'b0, 29'sd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
